fir_tap_mac: RTL and testbench
==============================

Name: fir_tap_mac

Overview:
- Sequential multiply-accumulate engine; the consumer (reader) side of the FIR tapped delay chain.
- On each 600 kHz sample strobe it snapshots one packed bank of TAPS signed 3-bit tap values and multiplies each by a stored coefficient. It accumulates over TAPS cycles of the 12 MHz clock and presents one signed partial sum with a valid pulse.
- Four instances, one per 10-tap bank, feed a downstream adder to form the 40-tap FIR output.

Parameters:
- TAPS, 10, number of taps per bank (one MAC cycle each).
- DATA_W, 3, signed tap sample width.
- COEF_W, 16, signed coefficient width.
- ACC_W, 23, signed accumulator/output width; must be >= DATA_W+COEF_W+ceil(log2(TAPS)).

Ports:
- iClk12M  in  1  12 MHz system clock.
- iRsn  in  1  reset, asynchronous, active-low.
- iEnSample600k  in  1  one-cycle start strobe; snapshot taps and begin MAC.
- iDelay  in  TAPS*DATA_W  packed taps; tap k at bits [k*DATA_W+DATA_W-1 : k*DATA_W].
- iCoeffWr  in  1  coefficient write enable.
- iCoeffAddr  in  4  coefficient index.
- iCoeffData  in  COEF_W  signed coefficient value.
- oMac  out  ACC_W  signed sum of tap[k]*coef[k], held until next result.
- oMacValid  out  1  one-cycle pulse; oMac updated.
- oBusy  out  1  high while a MAC is in progress (ACCUM or DONE).
- oOverrun  out  1  sticky; a start strobe arrived while busy.

Behaviour:
- Reset (iRsn low, asynchronous):
  - state=IDLE; accumulator, snapshot, index, all coefficients=0.
  - oMac=0, oMacValid=0, oBusy=0, oOverrun=0.
  - Asserting reset mid-operation aborts the MAC; no valid pulse is produced.
- States and transitions:
  - IDLE -> ACCUM: on edge N with iEnSample600k=1. Capture iDelay into the snapshot, clear the accumulator, set idx=0.
  - ACCUM: on each edge, acc <= acc + sext(tap[idx]) * coef[idx], then idx++. Edges N+1..N+TAPS. At edge N+TAPS (idx=TAPS-1 consumed) go to DONE.
  - DONE: on edge N+TAPS+1, oMac <= acc, oMacValid <= 1 for exactly one cycle, return to IDLE.
- Latency: oMacValid is high during the cycle after edge N+TAPS+1 (11 edges after the start strobe for TAPS=10). This fits inside the 20-cycle sample period.
- Arithmetic:
  - Taps and coefficients are two's complement.
  - Products are DATA_W+COEF_W bits, sign-extended to ACC_W before add.
  - No saturation needed; ACC_W is sized so overflow cannot occur.
- Snapshot: iDelay may change freely after the start edge; only the snapshot is used.
- oBusy: 1 from edge N through the DONE cycle inclusive; 0 in IDLE.
- Start while busy:
  - The strobe is ignored and the current MAC continues unchanged.
  - oOverrun is set to 1 and stays set until reset.
- Coefficient writes:
  - Accepted in any state; the register updates on the edge with iCoeffWr=1.
  - A MAC read of the same index on that edge uses the old value.
  - iCoeffAddr >= TAPS is ignored, with no side effects.
- Simultaneous iEnSample600k and iCoeffWr in IDLE: both take effect. The new coefficient is visible from the first ACCUM edge onward.

Decomposition:
- Shared package/include fir_pkg: TAPS, DATA_W, COEF_W, ACC_W defaults, state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2), tap-slice helper function.
- One sub-module: fir_tap_mult, a combinational signed DATA_W x COEF_W multiplier with sign-extended ACC_W output. It is reused by the future parallel FIR variant.

Test Plan:
1. Reset values: assert iRsn=0 at arbitrary time -> oMac=0, oMacValid=0, oBusy=0, oOverrun=0 immediately, without waiting for a clock edge.
2. Unit case: all coef=1, all taps=3'b001, start strobe -> oMacValid is a single pulse 11 edges later, oMac=10, oBusy high for 11 cycles.
3. Negative extreme: all taps=3'b100 (-4), all coef=32767 -> oMac=-1310680. Then all coef=-32768 with taps -4 -> oMac=1310720.
4. Impulse: tap3=3'b011, others 0, coef[k]=k+1. Change iDelay to all 1s on the cycle after start -> oMac=12, confirming the snapshot is used.
5. Overrun: second strobe 5 cycles after the first -> first result unchanged, exactly one valid pulse, oOverrun=1 and held through later samples.
6. Mid-operation events:
   - Reset at ACCUM idx=4 -> no valid pulse, coefficients cleared, next MAC returns 0.
   - Write to iCoeffAddr=12 -> ignored, next result unchanged.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and tap-slice helper for the FIR tap MAC family.
package fir_pkg;

    localparam int DEF_TAPS   = 10;
    localparam int DEF_DATA_W = 3;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_ACC_W  = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Extract tap k from a packed bank laid out at the default widths.
    function automatic logic signed [DEF_DATA_W-1:0] tap_slice(
        input logic [DEF_TAPS*DEF_DATA_W-1:0] bus,
        input int unsigned                    k
    );
        return bus[k*DEF_DATA_W +: DEF_DATA_W];
    endfunction

endpackage

// File: rtl/fir_tap_mult.sv
// Combinational signed tap x coefficient multiplier, product sign-extended to the accumulator width.
module fir_tap_mult #(
    parameter int DATA_W = 3,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 23
) (
    input  logic signed [DATA_W-1:0] tap,
    input  logic signed [COEF_W-1:0] coef,
    output logic signed [ACC_W-1:0]  prod
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] tap_ext;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] prod_full;

    assign tap_ext   = PROD_W'(tap);
    assign coef_ext  = PROD_W'(coef);
    assign prod_full = tap_ext * coef_ext;
    assign prod      = ACC_W'(prod_full);

endmodule

// File: rtl/fir_tap_mac.sv
// Sequential MAC over one bank of taps: snapshot on the sample strobe, one tap per clock,
// then present the signed partial sum with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | waiting for iEnSample600k
// ACCUM | one tap*coef product added per clock, idx 0..TAPS-1
// DONE  | publish accumulator to oMac, pulse oMacValid
module fir_tap_mac
    import fir_pkg::*;
#(
    parameter int TAPS   = DEF_TAPS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     iClk12M,
    input  logic                     iRsn,
    input  logic                     iEnSample600k,
    input  logic [TAPS*DATA_W-1:0]   iDelay,
    input  logic                     iCoeffWr,
    input  logic [3:0]               iCoeffAddr,
    input  logic signed [COEF_W-1:0] iCoeffData,
    output logic signed [ACC_W-1:0]  oMac,
    output logic                     oMacValid,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    state_t                   state_q, state_d;
    logic [TAPS*DATA_W-1:0]   snap_q, snap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  mac_q, mac_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];

    logic signed [DATA_W-1:0] tap_cur;
    logic signed [COEF_W-1:0] coef_cur;
    logic signed [ACC_W-1:0]  prod;
    logic                     last_tap;
    logic                     coef_wr_ok;

    assign last_tap   = (idx_q == IDX_W'(TAPS - 1));
    assign tap_cur    = snap_q[int'(idx_q)*DATA_W +: DATA_W];
    assign coef_cur   = coef_q[idx_q];
    assign coef_wr_ok = iCoeffWr && (int'(iCoeffAddr) < TAPS);

    fir_tap_mult #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .tap  (tap_cur),
        .coef (coef_cur),
        .prod (prod)
    );

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (iEnSample600k) state_d = ACCUM;
            ACCUM:   if (last_tap) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        snap_d    = snap_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        mac_d     = mac_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: begin
                if (iEnSample600k) begin
                    snap_d = iDelay;
                    acc_d  = '0;
                    idx_d  = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_q + prod;
                idx_d = idx_q + IDX_W'(1);
                if (iEnSample600k) overrun_d = 1'b1;
            end
            DONE: begin
                mac_d   = acc_q;
                valid_d = 1'b1;
                if (iEnSample600k) overrun_d = 1'b1;
            end
            default: ;
        endcase
    end

    // The MAC reads coef_q, so a same-edge write is seen from the following edge on.
    always_comb begin
        coef_d = coef_q;
        if (coef_wr_ok) coef_d[iCoeffAddr] = iCoeffData;
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            snap_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            mac_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) coef_q[k] <= '0;
        end else begin
            snap_q    <= snap_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            mac_q     <= mac_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            coef_q    <= coef_d;
        end
    end

    always_comb begin
        oMac      = mac_q;
        oMacValid = valid_q;
        oBusy     = (state_q != IDLE);
        oOverrun  = overrun_q;
    end

endmodule

// File: tb/tb_fir_tap_mac.sv
// Scoreboard bench for fir_tap_mac: expected sums come from an array model of the coefficients.
module tb_fir_tap_mac;
    import fir_pkg::*;

    localparam int TAPS   = DEF_TAPS;
    localparam int DATA_W = DEF_DATA_W;
    localparam int COEF_W = DEF_COEF_W;
    localparam int ACC_W  = DEF_ACC_W;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     en_sample = 1'b0;
    logic [TAPS*DATA_W-1:0]   delay_bus = '0;
    logic                     coef_wr = 1'b0;
    logic [3:0]               coef_addr = '0;
    logic signed [COEF_W-1:0] coef_data = '0;
    logic signed [ACC_W-1:0]  mac;
    logic                     mac_valid, busy, overrun;

    always #5 clk = ~clk;

    fir_tap_mac dut (
        .iClk12M       (clk),
        .iRsn          (rst_n),
        .iEnSample600k (en_sample),
        .iDelay        (delay_bus),
        .iCoeffWr      (coef_wr),
        .iCoeffAddr    (coef_addr),
        .iCoeffData    (coef_data),
        .oMac          (mac),
        .oMacValid     (mac_valid),
        .oBusy         (busy),
        .oOverrun      (overrun)
    );

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int coef_m[TAPS];
    int valid_seen = 0;
    int valid_exp = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int model_sum(input logic [TAPS*DATA_W-1:0] taps);
        int s = 0;
        for (int k = 0; k < TAPS; k++) s += int'(tap_slice(taps, k)) * coef_m[k];
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst_n && mac_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) check("unexpected_valid", 32'(mac_valid), 0);
            else check("mac_result", $signed(mac), exp_q.pop_front());
        end
    end

    task automatic write_coef(input logic [3:0] a, input logic signed [COEF_W-1:0] d);
        @(negedge clk);
        coef_wr = 1'b1; coef_addr = a; coef_data = d;
        if (int'(a) < TAPS) coef_m[a] = int'(d);
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    // Start one MAC; optionally write a coefficient on the same edge as the strobe.
    task automatic run_mac(input logic [TAPS*DATA_W-1:0] taps, input bit wr,
                           input logic [3:0] a, input logic signed [COEF_W-1:0] d,
                           input bit check_timing);
        int lat = 0;
        int busy_cnt = 0;
        @(negedge clk);
        en_sample = 1'b1;
        delay_bus = taps;
        if (wr) begin
            coef_wr = 1'b1; coef_addr = a; coef_data = d;
            if (int'(a) < TAPS) coef_m[a] = int'(d);
        end
        exp_q.push_back(model_sum(taps));
        valid_exp++;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                en_sample = 1'b0;
                coef_wr   = 1'b0;
                delay_bus = TAPS*DATA_W'($urandom);
            end
            if (busy) busy_cnt++;
            if (mac_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("valid_timeout", 0, 1);
        else if (check_timing) begin
            check("valid_latency_edges", lat - 1, TAPS + 1);
            check("busy_cycles", busy_cnt, TAPS + 1);
        end
        @(negedge clk);
        check("valid_single_pulse", 32'(mac_valid), 0);
    endtask

    task automatic set_all_coefs(input logic signed [COEF_W-1:0] d);
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), d);
    endtask

    logic [TAPS*DATA_W-1:0] taps_v;

    initial begin
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
        #1;
        check("rst_mac", $signed(mac), 0);
        check("rst_valid", 32'(mac_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Unit case
        set_all_coefs(16'sd1);
        taps_v = {TAPS{3'b001}};
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b1);

        // Negative extremes
        set_all_coefs(16'sd32767);
        taps_v = {TAPS{3'b100}};
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b0);
        set_all_coefs(-16'sd32768);
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b0);

        // Impulse at tap 3; iDelay scrambles after the start edge
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'(k + 1));
        taps_v = '0;
        taps_v[3*DATA_W +: DATA_W] = 3'b011;
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b1);
        check("overrun_clear_before", 32'(overrun), 0);

        // Overrun: second strobe 5 cycles into the first MAC
        @(negedge clk);
        en_sample = 1'b1;
        delay_bus = {TAPS{3'b001}};
        exp_q.push_back(model_sum({TAPS{3'b001}}));
        valid_exp++;
        @(negedge clk);
        en_sample = 1'b0;
        repeat (4) @(negedge clk);
        en_sample = 1'b1;
        delay_bus = {TAPS{3'b011}};
        @(negedge clk);
        en_sample = 1'b0;
        begin
            int got = 0;
            for (int i = 0; i < 30 && got == 0; i++) begin
                @(negedge clk);
                if (mac_valid) got = 1;
            end
            check("overrun_valid_seen", got, 1);
        end
        repeat (15) @(negedge clk);
        check("overrun_set", 32'(overrun), 1);
        taps_v = TAPS*DATA_W'($urandom);
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b1);
        check("overrun_held", 32'(overrun), 1);

        // Reset mid-ACCUM at idx 4, checked immediately without a clock edge
        @(negedge clk);
        en_sample = 1'b1;
        delay_bus = {TAPS{3'b001}};
        @(negedge clk);
        en_sample = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mac", $signed(mac), 0);
        check("midrst_valid", 32'(mac_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_overrun", 32'(overrun), 0);
        for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        taps_v = {TAPS{3'b011}};
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b0);

        // Out-of-range coefficient address must be ignored
        for (int k = 0; k < TAPS; k++) write_coef(4'(k), 16'($urandom));
        taps_v = TAPS*DATA_W'($urandom);
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b0);
        write_coef(4'd12, 16'sh7abc);
        run_mac(taps_v, 1'b0, 4'd0, '0, 1'b0);

        // Simultaneous strobe and write: new coefficient used from the first ACCUM edge
        run_mac({TAPS{3'b010}}, 1'b1, 4'd0, 16'sh1234, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            int nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) write_coef(4'($urandom_range(0, 15)), 16'($urandom));
            taps_v = TAPS*DATA_W'($urandom);
            run_mac(taps_v, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                    16'($urandom), (n % 5 == 0));
        end

        repeat (5) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        check("valid_count", valid_seen, valid_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
